// File: rtl/vpu_pkg.sv
// Shared VPU definitions: lane count, lane index type, demux lane-selection mode.
package vpu_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic {
    LM_DIRECTED = 1'b0,
    LM_SCATTER  = 1'b1
  } lane_mode_e;

  // Round-robin successor; the 2-bit index wraps 3 -> 0 by itself.
  function automatic lane_idx_t rr_next(input lane_idx_t ptr);
    return ptr + lane_idx_t'(1);
  endfunction

endpackage

// File: rtl/lane_out_reg.sv
// One-entry output slice for a single lane: loads a beat, holds it until the
// consumer takes it, and lets a new load replace a draining entry without a bubble.
module lane_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Valid/data register: load wins over drain; data is kept (not cleared) after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lane_demux_1x4.sv
// Stream demultiplexer from the element fetch stage to the four per-lane execution
// pipes. The target lane comes from in_sel (directed) or a round-robin pointer
// (scatter); a full lane stalls only beats aimed at it.
module lane_demux_1x4
  import vpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = vpu_pkg::NUM_LANES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [1:0]                  in_sel,
  input  logic                        in_mode,
  input  logic                        in_last,
  output logic [NUM_LANES-1:0]        out_valid,
  input  logic [NUM_LANES-1:0]        out_ready,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic                        busy
);

  lane_mode_e           mode;
  lane_idx_t            rr_ptr;
  lane_idx_t            target;
  logic                 accept;
  logic [NUM_LANES-1:0] load_en;

  assign mode = lane_mode_e'(in_mode);

  // Target lane and readiness: in_ready depends on lane state and out_ready, never on in_valid.
  always_comb begin
    target   = (mode == LM_SCATTER) ? rr_ptr : lane_idx_t'(in_sel);
    in_ready = !out_valid[target] || out_ready[target];
    accept   = in_valid && in_ready;
  end

  // One-hot load enable for the targeted lane on an accepted beat.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    load_en = '0;
    if (accept) begin
      load_en[target] = 1'b1;
    end
  end

  // Round-robin pointer: in_last on any accepted beat restarts at lane 0, ahead of the scatter increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (in_last) begin
        rr_ptr <= '0;
      end else if (mode == LM_SCATTER) begin
        rr_ptr <= rr_next(rr_ptr);
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_out_reg #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_en[i]),
      .load_data(in_data),
      .drain    (out_ready[i]),
      .valid    (out_valid[i]),
      .data     (out_data[i*DATA_W +: DATA_W])
    );
  end

  assign busy = |out_valid;

endmodule
